window_spill_fill: RTL and testbench

WINDOW_SPILL_FILL -- requirements
Module: window_spill_fill

---
 rtl/sparc_pkg.sv | 24 ++
 rtl/window_spill_fill.sv | 200 ++++++++++++++++++++
 tb/tb_window_spill_fill.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sparc_pkg.sv
// Shared definitions for the register-window spill/fill engine:
// controller states, window geometry and a small one-hot helper.
package sparc_pkg;

    localparam int NWIN           = 4;
    localparam int REGS_PER_SPILL = 16;
    localparam int FRAME_BYTES    = 64;

    // Controller states. busy is simply "not IDLE".
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SP_RD = 3'd1,
        SP_WR = 3'd2,
        FL_RD = 3'd3,
        FL_WR = 3'd4,
        DONE  = 3'd5
    } wsf_state_t;

    // One-hot encoding of a window number, used for the invalid-window mask.
    function automatic logic [NWIN-1:0] win_onehot(input logic [1:0] win);
        return 4'b0001 << win;
    endfunction

endpackage

// File: rtl/window_spill_fill.sv
// Register-window spill/fill controller.
// Tracks the current window pointer, the invalid-window mask and how many
// windows are parked in memory. A save into the invalid window spills the
// oldest window (r16..r31) to memory; a restore into the invalid window with
// spilled windows outstanding fills it back. All other save/restore requests
// just move cwp. Optional build macro SPILL_CNT_EN adds saturating
// spill/fill event counters as extra outputs.
module window_spill_fill
    import sparc_pkg::*;
#(
    parameter logic [31:0] SPILL_BASE = 32'h0000_1000
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        save,
    input  logic        restore,
    output logic [1:0]  cwp,
    output logic        busy,
    output logic        err,
    output logic        rf_enable,
    output logic        rf_rw,
    output logic [1:0]  rf_win,
    output logic [4:0]  rf_r_num,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef SPILL_CNT_EN
    ,
    output logic [7:0]  spill_cnt,
    output logic [7:0]  fill_cnt
`endif
);

    localparam logic [3:0] LAST_IDX = 4'(REGS_PER_SPILL - 1);

    wsf_state_t  state, state_d;
    logic [3:0]  wim;
    logic [3:0]  depth;
    logic [3:0]  idx;
    logic [3:0]  slot;
    logic [1:0]  target;
    logic        is_fill;

    logic [1:0]  cwp_dec;
    logic [1:0]  cwp_inc;
    logic        save_ovf;
    logic        rest_unf;
    logic        conflict;
    logic        start_spill;
    logic        start_fill;
    logic [31:0] xfer_addr;

    // Window arithmetic and request classification seen from IDLE.
    always_comb begin
        cwp_dec     = cwp - 2'd1;
        cwp_inc     = cwp + 2'd1;
        save_ovf    = wim[cwp_dec];
        rest_unf    = wim[cwp_inc];
        conflict    = save && restore;
        start_spill = !conflict && save && save_ovf && (depth != 4'd15);
        start_fill  = !conflict && restore && !save && rest_unf && (depth != 4'd0);
        xfer_addr   = SPILL_BASE + 32'(slot) * 32'(FRAME_BYTES) + {26'd0, idx, 2'b00};
    end

    // State register; an asynchronous clear abandons any transfer in flight.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) state <= IDLE;
        else      state <= state_d;
    end

    // Next-state logic and the register-file / memory handshake outputs.
    always_comb begin
        state_d   = state;
        busy      = (state != IDLE);
        rf_enable = 1'b0;
        rf_rw     = 1'b0;
        rf_win    = 2'd0;
        rf_r_num  = 5'd0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        case (state)
            IDLE: begin
                if (start_spill)     state_d = SP_RD;
                else if (start_fill) state_d = FL_RD;
            end
            SP_RD: begin
                rf_enable = 1'b1;
                rf_win    = target;
                rf_r_num  = {1'b1, idx};
                state_d   = SP_WR;
            end
            SP_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = xfer_addr;
                if (mem_ack) state_d = (idx == LAST_IDX) ? DONE : SP_RD;
            end
            FL_RD: begin
                mem_req  = 1'b1;
                mem_addr = xfer_addr;
                if (mem_ack) state_d = FL_WR;
            end
            FL_WR: begin
                rf_enable = 1'b1;
                rf_rw     = 1'b1;
                rf_win    = target;
                rf_r_num  = {1'b1, idx};
                state_d   = (idx == LAST_IDX) ? DONE : FL_RD;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Window bookkeeping, beat counter and data latches. cwp/wim/depth only
    // change on a plain move in IDLE or once a whole transfer reaches DONE.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            cwp       <= 2'd0;
            wim       <= 4'b0010;
            depth     <= 4'd0;
            idx       <= 4'd0;
            slot      <= 4'd0;
            target    <= 2'd0;
            is_fill   <= 1'b0;
            err       <= 1'b0;
            mem_wdata <= 32'd0;
            rf_wdata  <= 32'd0;
`ifdef SPILL_CNT_EN
            spill_cnt <= 8'd0;
            fill_cnt  <= 8'd0;
`endif
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (conflict) begin
                        err <= 1'b1;
                    end else if (save) begin
                        if (!save_ovf) begin
                            cwp <= cwp_dec;
                        end else if (depth == 4'd15) begin
                            err <= 1'b1;
                        end else begin
                            target  <= cwp - 2'd2;
                            slot    <= depth;
                            idx     <= 4'd0;
                            is_fill <= 1'b0;
                        end
                    end else if (restore) begin
                        if (!rest_unf) begin
                            cwp <= cwp_inc;
                        end else if (depth == 4'd0) begin
                            err <= 1'b1;
                        end else begin
                            target  <= cwp_inc;
                            slot    <= depth - 4'd1;
                            idx     <= 4'd0;
                            is_fill <= 1'b1;
                        end
                    end
                end
                SP_RD: mem_wdata <= rf_rdata;
                SP_WR: if (mem_ack && idx != LAST_IDX) idx <= idx + 4'd1;
                FL_RD: if (mem_ack) rf_wdata <= mem_rdata;
                FL_WR: if (idx != LAST_IDX) idx <= idx + 4'd1;
                DONE: begin
                    idx <= 4'd0;
                    if (is_fill) begin
                        wim   <= win_onehot(cwp + 2'd2);
                        cwp   <= cwp_inc;
                        depth <= depth - 4'd1;
`ifdef SPILL_CNT_EN
                        if (fill_cnt != 8'hFF) fill_cnt <= fill_cnt + 8'd1;
`endif
                    end else begin
                        wim   <= win_onehot(target);
                        cwp   <= cwp_dec;
                        depth <= depth + 4'd1;
`ifdef SPILL_CNT_EN
                        if (spill_cnt != 8'hFF) spill_cnt <= spill_cnt + 8'd1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_window_spill_fill.sv
// Directed bench for window_spill_fill with a register-file pattern model,
// a memory model with programmable ack delay and a transaction scoreboard.
module tb_window_spill_fill;

    localparam logic [31:0] BASE = 32'h0000_1000;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_txn_t;

    typedef struct {
        logic [1:0]  win;
        logic [4:0]  num;
        logic [31:0] data;
    } rf_txn_t;

    logic        Clk = 1'b0;
    logic        Clr = 1'b0;
    logic        save = 1'b0;
    logic        restore = 1'b0;
    logic [1:0]  cwp;
    logic        busy;
    logic        err;
    logic        rf_enable;
    logic        rf_rw;
    logic [1:0]  rf_win;
    logic [4:0]  rf_r_num;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
`ifdef SPILL_CNT_EN
    logic [7:0]  spill_cnt;
    logic [7:0]  fill_cnt;
`endif

    int total = 0;
    int bad = 0;
    int ack_delay = 0;
    int write_cnt = 0;
    int read_cnt = 0;
    int req_cycles = 0;

    mem_txn_t    mem_q[$];
    rf_txn_t     rf_q[$];
    logic [31:0] mem [logic [31:0]];

    window_spill_fill #(.SPILL_BASE(BASE)) dut (
        .Clk(Clk), .Clr(Clr), .save(save), .restore(restore),
        .cwp(cwp), .busy(busy), .err(err),
        .rf_enable(rf_enable), .rf_rw(rf_rw), .rf_win(rf_win),
        .rf_r_num(rf_r_num), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef SPILL_CNT_EN
        , .spill_cnt(spill_cnt), .fill_cnt(fill_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    // Every register holds a value unique to its window and number.
    function automatic logic [31:0] pattern(input logic [1:0] w, input logic [4:0] n);
        return {8'hA5, 6'd0, w, 11'd0, n};
    endfunction

    always_comb rf_rdata = pattern(rf_win, rf_r_num);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r);
        @(negedge Clk);
        save = s;
        restore = r;
        @(posedge Clk);
        #1;
        save = 1'b0;
        restore = 1'b0;
    endtask

    task automatic waitIdle(input int limit, output int cycles);
        cycles = 0;
        while (busy && cycles < limit) begin
            @(posedge Clk);
            #1;
            cycles++;
        end
        checkOutput("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic pushSpill(input logic [1:0] win, input logic [3:0] slot);
        for (int i = 0; i < 16; i++) begin
            mem_txn_t t;
            t.we = 1'b1;
            t.addr = BASE + 32'(slot) * 32'd64 + 32'(i) * 32'd4;
            t.data = pattern(win, 5'(16 + i));
            mem_q.push_back(t);
        end
    endtask

    task automatic pushFill(input logic [1:0] win, input logic [3:0] slot);
        for (int i = 0; i < 16; i++) begin
            mem_txn_t t;
            rf_txn_t  r;
            t.we = 1'b0;
            t.addr = BASE + 32'(slot) * 32'd64 + 32'(i) * 32'd4;
            t.data = 32'd0;
            mem_q.push_back(t);
            r.win = win;
            r.num = 5'(16 + i);
            r.data = pattern(win, 5'(16 + i));
            rf_q.push_back(r);
        end
    endtask

    // Memory model: ack after ack_delay wait cycles, scoreboard each beat,
    // and check that a pending request holds steady with the rf idle.
    logic        in_beat = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] beat_addr;
    logic        beat_we;
    always @(negedge Clk) begin
        mem_ack = 1'b0;
        if (Clr && mem_req) begin
            req_cycles++;
            checkOutput("rf_idle_during_req", {31'd0, rf_enable}, 32'd0);
            if (!in_beat) begin
                in_beat = 1'b1;
                wait_cnt = 0;
                beat_addr = mem_addr;
                beat_we = mem_we;
            end else begin
                checkOutput("addr_stable", mem_addr, beat_addr);
                checkOutput("we_stable", {31'd0, mem_we}, {31'd0, beat_we});
            end
            if (wait_cnt == ack_delay) begin
                mem_ack = 1'b1;
                in_beat = 1'b0;
                if (mem_q.size() == 0) begin
                    checkOutput("unexpected_mem_txn", 32'd1, 32'd0);
                end else begin
                    mem_txn_t e;
                    e = mem_q.pop_front();
                    checkOutput("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                    checkOutput("mem_addr", mem_addr, e.addr);
                    if (e.we) begin
                        checkOutput("mem_wdata", mem_wdata, e.data);
                    end
                end
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    write_cnt++;
                end else begin
                    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'hDEAD_BEEF;
                    read_cnt++;
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            in_beat = 1'b0;
        end
    end

    // Register-file write checker: every fill write must match the scoreboard.
    always @(negedge Clk) begin
        if (Clr && rf_enable && rf_rw) begin
            if (rf_q.size() == 0) begin
                checkOutput("unexpected_rf_write", 32'd1, 32'd0);
            end else begin
                rf_txn_t e;
                e = rf_q.pop_front();
                checkOutput("rf_win", {30'd0, rf_win}, {30'd0, e.win});
                checkOutput("rf_r_num", {27'd0, rf_r_num}, {27'd0, e.num});
                checkOutput("rf_wdata", rf_wdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int req_before;
        int base_w;
        int guard;

        $display("[TB] starting");
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("reset_cwp", {30'd0, cwp}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_err", {31'd0, err}, 32'd0);
        checkOutput("reset_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("reset_rf_enable", {31'd0, rf_enable}, 32'd0);
        @(negedge Clk);
        Clr = 1'b1;

        // Restore straight out of reset underflows with nothing spilled.
        applyStimulus(1'b0, 1'b1);
        checkOutput("underflow_err", {31'd0, err}, 32'd1);
        checkOutput("underflow_cwp", {30'd0, cwp}, 32'd0);
        @(posedge Clk);
        #1;
        checkOutput("err_one_cycle", {31'd0, err}, 32'd0);

        // Two plain saves.
        req_before = req_cycles;
        applyStimulus(1'b1, 1'b0);
        checkOutput("save1_cwp", {30'd0, cwp}, 32'd3);
        checkOutput("save1_busy", {31'd0, busy}, 32'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("save2_cwp", {30'd0, cwp}, 32'd2);
        checkOutput("save2_busy", {31'd0, busy}, 32'd0);

        // Save and restore together is rejected.
        applyStimulus(1'b1, 1'b1);
        checkOutput("conflict_err", {31'd0, err}, 32'd1);
        checkOutput("conflict_cwp", {30'd0, cwp}, 32'd2);
        checkOutput("plain_moves_no_req", 32'(req_cycles - req_before), 32'd0);

        // Third save overflows: window 0 spilled to slot 0.
        pushSpill(2'd0, 4'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("spill_busy", {31'd0, busy}, 32'd1);
        waitIdle(200, cyc);
        checkOutput("spill_latency", 32'(cyc), 32'd33);
        checkOutput("spill_cwp", {30'd0, cwp}, 32'd1);
        checkOutput("spill_writes", 32'(write_cnt), 32'd16);
        checkOutput("spill_q_empty", 32'(mem_q.size()), 32'd0);

        // Restores: two plain moves, then a fill of window 0.
        req_before = req_cycles;
        applyStimulus(1'b0, 1'b1);
        checkOutput("restore1_cwp", {30'd0, cwp}, 32'd2);
        applyStimulus(1'b0, 1'b1);
        checkOutput("restore2_cwp", {30'd0, cwp}, 32'd3);
        checkOutput("restore_moves_no_req", 32'(req_cycles - req_before), 32'd0);
        pushFill(2'd0, 4'd0);
        applyStimulus(1'b0, 1'b1);
        waitIdle(200, cyc);
        checkOutput("fill_latency", 32'(cyc), 32'd33);
        checkOutput("fill_cwp", {30'd0, cwp}, 32'd0);
        checkOutput("fill_reads", 32'(read_cnt), 32'd16);
        checkOutput("fill_mem_q_empty", 32'(mem_q.size()), 32'd0);
        checkOutput("fill_rf_q_empty", 32'(rf_q.size()), 32'd0);

        // Depth is back to zero, so a further underflow is an error.
        applyStimulus(1'b0, 1'b1);
        checkOutput("depth0_err", {31'd0, err}, 32'd1);
        checkOutput("depth0_cwp", {30'd0, cwp}, 32'd0);

        // Spill again with a three-cycle ack delay per beat.
        ack_delay = 3;
        applyStimulus(1'b1, 1'b0);
        checkOutput("slow_save1_cwp", {30'd0, cwp}, 32'd3);
        applyStimulus(1'b1, 1'b0);
        checkOutput("slow_save2_cwp", {30'd0, cwp}, 32'd2);
        pushSpill(2'd0, 4'd0);
        applyStimulus(1'b1, 1'b0);
        waitIdle(400, cyc);
        checkOutput("slow_spill_latency", 32'(cyc), 32'd81);
        checkOutput("slow_spill_cwp", {30'd0, cwp}, 32'd1);
        checkOutput("slow_q_empty", 32'(mem_q.size()), 32'd0);

        // Second-level spill of window 3 to slot 1, aborted by reset at idx 7.
        ack_delay = 0;
        base_w = write_cnt;
        pushSpill(2'd3, 4'd1);
        applyStimulus(1'b1, 1'b0);
        guard = 0;
        while (write_cnt < base_w + 7 && guard < 100) begin
            @(negedge Clk);
            guard++;
        end
        checkOutput("abort_reached_idx7", 32'(write_cnt - base_w), 32'd7);
        @(posedge Clk);
        #1;
        Clr = 1'b0;
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_cwp", {30'd0, cwp}, 32'd0);
        checkOutput("abort_mem_req", {31'd0, mem_req}, 32'd0);
        mem_q.delete();
        @(negedge Clk);
        Clr = 1'b1;

        // After the abort nothing is spilled: restore underflows, save moves.
        applyStimulus(1'b0, 1'b1);
        checkOutput("abort_depth0_err", {31'd0, err}, 32'd1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("abort_save_cwp", {30'd0, cwp}, 32'd3);
        checkOutput("abort_save_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
